// File: rtl/kamacore_stage_ex.sv
// kamacore_stage_ex -- execute stage of the kamacore pipeline.
//
// Selects operands (with MEM-stage forwarding), computes single-cycle ALU
// results, and runs MUL / DIVU / REMU on a shared iterative unit that
// stalls decode until the result is ready. The result is written into the
// EX/MEM stage buffer (ex_* outputs).
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   flush               kill the instruction in EX (aborts multi-cycle ops)
//   id_*                instruction, operands and register indices from ID
//   fwd_we/fwd_a/fwd_data  MEM-stage forwarding path
//   stall               ID must hold its outputs this cycle
//   ex_*                EX/MEM stage buffer
//
// Handshake: ID presents an instruction with id_valid=1. It is consumed at
// the next posedge unless stall=1 in that cycle, in which case ID holds all
// id_* inputs unchanged. There is no backpressure from the memory stage.
module kamacore_stage_ex #(
  parameter int CPU_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [3:0]                id_op,
  input  logic [CPU_WIDTH-1:0]      id_src1,
  input  logic [CPU_WIDTH-1:0]      id_src2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_rd_we,
  input  logic [31:0]               id_instruction,
  input  logic                      fwd_we,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_a,
  input  logic [CPU_WIDTH-1:0]      fwd_data,
  output logic                      stall,
  output logic                      ex_valid,
  output logic [CPU_WIDTH-1:0]      ex_alu_result,
  output logic [31:0]               ex_instruction,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_rd_we
);

  localparam int W  = CPU_WIDTH;
  localparam int SW = $clog2(W);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;
  localparam logic [3:0] OP_REMU  = 4'd12;
  localparam logic [3:0] OP_PASS2 = 4'd13;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                      state_q, state_d;
  logic [SW-1:0]               cnt_q, cnt_d;
  logic [W-1:0]                acc_q, acc_d;   // MUL accumulator / DIV partial remainder
  logic [W-1:0]                opa_q, opa_d;   // MUL multiplicand / DIV dividend->quotient
  logic [W-1:0]                opb_q, opb_d;   // MUL multiplier / DIV divisor
  logic [3:0]                  mop_q, mop_d;
  logic [31:0]                 m_instr_q, m_instr_d;
  logic [REG_ADDR_WIDTH-1:0]   m_rd_q, m_rd_d;
  logic                        m_rd_we_q, m_rd_we_d;

  logic                        ex_valid_q, ex_valid_d;
  logic [W-1:0]                ex_result_q, ex_result_d;
  logic [31:0]                 ex_instr_q, ex_instr_d;
  logic [REG_ADDR_WIDTH-1:0]   ex_rd_q, ex_rd_d;
  logic                        ex_rd_we_q, ex_rd_we_d;

  logic                        stall_c;

  // Operand selection: forward the MEM-stage value when it targets the
  // source register; x0 is never forwarded.
  logic [W-1:0] src1, src2;
  always_comb begin
    src1 = id_src1;
    src2 = id_src2;
    if (fwd_we && (fwd_a != '0) && (fwd_a == id_rs1)) src1 = fwd_data;
    if (fwd_we && (fwd_a != '0) && (fwd_a == id_rs2)) src2 = fwd_data;
  end

  // Single-cycle ALU.
  logic [SW-1:0] shamt;
  logic [W-1:0]  alu_res;
  logic          is_multi;
  assign shamt    = src2[SW-1:0];
  assign is_multi = (id_op == OP_MUL) || (id_op == OP_DIVU) || (id_op == OP_REMU);

  always_comb begin
    alu_res = '0;
    case (id_op)
      OP_ADD:   alu_res = src1 + src2;
      OP_SUB:   alu_res = src1 - src2;
      OP_AND:   alu_res = src1 & src2;
      OP_OR:    alu_res = src1 | src2;
      OP_XOR:   alu_res = src1 ^ src2;
      OP_SLL:   alu_res = src1 << shamt;
      OP_SRL:   alu_res = src1 >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(src1) >>> shamt);
      OP_SLT:   alu_res = {{(W-1){1'b0}}, ($signed(src1) < $signed(src2))};
      OP_SLTU:  alu_res = {{(W-1){1'b0}}, (src1 < src2)};
      OP_PASS2: alu_res = src2;
      default:  alu_res = '0;
    endcase
  end

  // One iteration of the iterative unit, computed from the current state.
  // Restoring division shifts {rem, quotient} left, trial-subtracts the
  // divisor and keeps the difference when it does not borrow. A zero divisor
  // never borrows, which yields quotient all-ones and remainder = dividend.
  logic [W:0]   rem_sh, diff;
  logic [W-1:0] acc_n, opa_n, opb_n, iter_res;
  always_comb begin
    rem_sh   = {acc_q, opa_q[W-1]};
    diff     = rem_sh - {1'b0, opb_q};
    acc_n    = acc_q;
    opa_n    = opa_q;
    opb_n    = opb_q;
    iter_res = '0;
    if (mop_q == OP_MUL) begin
      acc_n    = acc_q + (opb_q[0] ? opa_q : '0);
      opa_n    = opa_q << 1;
      opb_n    = opb_q >> 1;
      iter_res = acc_n;
    end else begin
      if (!diff[W]) begin
        acc_n = diff[W-1:0];
        opa_n = {opa_q[W-2:0], 1'b1};
      end else begin
        acc_n = rem_sh[W-1:0];
        opa_n = {opa_q[W-2:0], 1'b0};
      end
      iter_res = (mop_q == OP_REMU) ? acc_n : opa_n;
    end
  end

  // FSM next-state and outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    mop_d       = mop_q;
    m_instr_d   = m_instr_q;
    m_rd_d      = m_rd_q;
    m_rd_we_d   = m_rd_we_q;
    stall_c     = 1'b0;
    ex_valid_d  = 1'b0;
    ex_result_d = '0;
    ex_instr_d  = '0;
    ex_rd_d     = '0;
    ex_rd_we_d  = 1'b0;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (id_valid) begin
            if (is_multi) begin
              // Latch operands and metadata; EX/MEM receives a bubble.
              stall_c   = 1'b1;
              acc_d     = '0;
              opa_d     = src1;
              opb_d     = src2;
              mop_d     = id_op;
              cnt_d     = SW'(W-1);
              m_instr_d = id_instruction;
              m_rd_d    = id_rd;
              m_rd_we_d = id_rd_we;
              state_d   = BUSY;
            end else begin
              ex_valid_d  = 1'b1;
              ex_result_d = alu_res;
              ex_instr_d  = id_instruction;
              ex_rd_d     = id_rd;
              ex_rd_we_d  = id_rd_we;
            end
          end
        end
        BUSY: begin
          acc_d = acc_n;
          opa_d = opa_n;
          opb_d = opb_n;
          cnt_d = cnt_q - SW'(1);
          if (cnt_q != '0) begin
            stall_c = 1'b1;
          end else begin
            // Final iteration: release ID and publish the result.
            ex_valid_d  = 1'b1;
            ex_result_d = iter_res;
            ex_instr_d  = m_instr_q;
            ex_rd_d     = m_rd_q;
            ex_rd_we_d  = m_rd_we_q;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      mop_q       <= '0;
      m_instr_q   <= '0;
      m_rd_q      <= '0;
      m_rd_we_q   <= 1'b0;
      ex_valid_q  <= 1'b0;
      ex_result_q <= '0;
      ex_instr_q  <= '0;
      ex_rd_q     <= '0;
      ex_rd_we_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      mop_q       <= mop_d;
      m_instr_q   <= m_instr_d;
      m_rd_q      <= m_rd_d;
      m_rd_we_q   <= m_rd_we_d;
      ex_valid_q  <= ex_valid_d;
      ex_result_q <= ex_result_d;
      ex_instr_q  <= ex_instr_d;
      ex_rd_q     <= ex_rd_d;
      ex_rd_we_q  <= ex_rd_we_d;
    end
  end

  // Stall is held low while reset is asserted.
  assign stall          = stall_c & rst;
  assign ex_valid       = ex_valid_q;
  assign ex_alu_result  = ex_result_q;
  assign ex_instruction = ex_instr_q;
  assign ex_rd          = ex_rd_q;
  assign ex_rd_we       = ex_rd_we_q;

endmodule

// File: tb/tb_kamacore_stage_ex.sv
// Directed testbench for kamacore_stage_ex (W=32, 5-bit register indices).
module tb_kamacore_stage_ex;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic [3:0]  id_op;
  logic [31:0] id_src1;
  logic [31:0] id_src2;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_rd_we;
  logic [31:0] id_instruction;
  logic        fwd_we;
  logic [4:0]  fwd_a;
  logic [31:0] fwd_data;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_instruction;
  logic [4:0]  ex_rd;
  logic        ex_rd_we;

  int n_cmp = 0;
  int n_err = 0;
  int seq   = 0;

  kamacore_stage_ex #(.CPU_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_op(id_op), .id_src1(id_src1), .id_src2(id_src2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_instruction(id_instruction),
    .fwd_we(fwd_we), .fwd_a(fwd_a), .fwd_data(fwd_data),
    .stall(stall), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_instruction(ex_instruction), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: present one instruction with a unique instruction word and rd.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    seq++;
    id_valid       = 1'b1;
    id_op          = op;
    id_src1        = a;
    id_src2        = b;
    id_rs1         = rs1;
    id_rs2         = rs2;
    id_rd          = 5'(seq) | 5'd1;
    id_rd_we       = 1'b1;
    id_instruction = 32'hA500_0000 + 32'(seq);
  endtask

  task automatic check_out(input string tag, input logic [31:0] exp);
    chk({tag, ".valid"}, 32'(ex_valid), 32'd1);
    chk({tag, ".result"}, ex_alu_result, exp);
    chk({tag, ".rd"}, 32'(ex_rd), 32'(5'(seq) | 5'd1));
    chk({tag, ".rd_we"}, 32'(ex_rd_we), 32'd1);
    chk({tag, ".instr"}, ex_instruction, 32'hA500_0000 + 32'(seq));
  endtask

  task automatic check_bubble(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'd0);
    chk({tag, ".result"}, ex_alu_result, 32'd0);
    chk({tag, ".rd"}, 32'(ex_rd), 32'd0);
    chk({tag, ".rd_we"}, 32'(ex_rd_we), 32'd0);
    chk({tag, ".instr"}, ex_instruction, 32'd0);
  endtask

  task automatic single(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    drive(op, a, b, 5'd0, 5'd0);
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'd0);
    step();
    check_out(tag, exp);
    id_valid = 1'b0;
  endtask

  task automatic fwd_case(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic we, input logic [4:0] fa, input logic [31:0] exp);
    fwd_we   = we;
    fwd_a    = fa;
    fwd_data = 32'd100;
    drive(4'd0, 32'd1, 32'd2, rs1, rs2);
    step();
    check_out(tag, exp);
    id_valid = 1'b0;
    fwd_we   = 1'b0;
    fwd_a    = 5'd0;
    fwd_data = 32'd0;
  endtask

  // Multi-cycle op: counts stall cycles, checks bubbles during BUSY, then
  // checks the result in the cycle after stall drops. Leaves id_valid=0 in
  // that cycle so the caller may present the next instruction back-to-back.
  task automatic multi(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n;
    drive(op, a, b, 5'd0, 5'd0);
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      step();
      chk({tag, ".busy_valid"}, 32'(ex_valid), 32'd0);
    end
    chk({tag, ".stall_cycles"}, 32'(n), 32'd32);
    chk({tag, ".stall_low"}, 32'(stall), 32'd0);
    step();
    check_out(tag, exp);
    id_valid = 1'b0;
  endtask

  task automatic abort(input string tag, input logic use_rst);
    drive(4'd11, 32'd100, 32'd7, 5'd0, 5'd0);
    #1;
    chk({tag, ".stall_start"}, 32'(stall), 32'd1);
    repeat (10) step();
    if (use_rst) rst = 1'b0;
    else flush = 1'b1;
    #1;
    chk({tag, ".stall_abort"}, 32'(stall), 32'd0);
    step();
    rst      = 1'b1;
    flush    = 1'b0;
    id_valid = 1'b0;
    check_bubble(tag);
    #1;
    chk({tag, ".stall_after"}, 32'(stall), 32'd0);
    single({tag, ".add"}, 4'd0, 32'd2, 32'd2, 32'd4);
  endtask

  initial begin
    // Reset block
    rst = 1'b0; flush = 1'b0; id_valid = 1'b0; id_op = 4'd0;
    id_src1 = '0; id_src2 = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rd_we = 1'b0; id_instruction = '0; fwd_we = 1'b0; fwd_a = '0; fwd_data = '0;
    step();
    step();
    check_bubble("reset");
    chk("reset.stall", 32'(stall), 32'd0);
    rst = 1'b1;
    step();
    check_bubble("idle");

    // 1. basic ALU
    single("add", 4'd0, 32'd5, 32'd7, 32'd12);
    single("sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE);
    single("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
    single("or",  4'd3, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11);
    single("xor", 4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);

    // 2. forwarding
    fwd_case("fwd_rs1",   5'd3, 5'd0, 1'b1, 5'd3, 32'd102);
    fwd_case("fwd_x0",    5'd0, 5'd0, 1'b1, 5'd0, 32'd3);
    fwd_case("fwd_no_we", 5'd3, 5'd0, 1'b0, 5'd3, 32'd3);
    fwd_case("fwd_rs2",   5'd0, 5'd3, 1'b1, 5'd3, 32'd101);
    fwd_case("fwd_miss",  5'd4, 5'd5, 1'b1, 5'd3, 32'd3);

    // 3. MUL with back-to-back follower
    multi("mul", 4'd10, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
    single("after_mul", 4'd0, 32'd10, 32'd20, 32'd30);

    // 4. division
    multi("divu", 4'd11, 32'd100, 32'd7, 32'd14);
    multi("remu", 4'd12, 32'd100, 32'd7, 32'd2);
    multi("divu0", 4'd11, 32'h1234, 32'd0, 32'hFFFF_FFFF);
    multi("remu0", 4'd12, 32'h1234, 32'd0, 32'h1234);
    multi("mul2", 4'd10, 32'd12345, 32'd678, 32'd8369910);

    // 5. shifts and compares
    single("sra",   4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000);
    single("srl",   4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000);
    single("sll",   4'd5, 32'd1, 32'd35, 32'd8);
    single("slt",   4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1);
    single("sltu",  4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0);
    single("pass2", 4'd13, 32'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    single("op14",  4'd14, 32'd9, 32'd9, 32'd0);
    single("op15",  4'd15, 32'd9, 32'd9, 32'd0);

    // idle cycle gives a bubble
    step();
    check_bubble("bubble");

    // 6. abort mid-DIVU
    abort("abort_rst", 1'b1);
    abort("abort_flush", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kamacore_stage_ex.md
Name: kamacore_stage_ex

Overview:
Execute stage of the kamacore pipeline. It sits between decode (ID) and the memory stage, and produces the EX/MEM stage buffer that the memory stage consumes. It selects operands, using the MEM-stage forwarding path when that path carries a newer value. It computes single-cycle ALU results directly. MUL, DIVU and REMU run on an iterative shift-add/restore unit, which stalls decode until the result is ready.

Parameters:
CPU_WIDTH, 32, datapath width W (power of two, >= 8)
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
flush  in  1  kill the instruction in EX, including any in-flight multi-cycle op
id_valid  in  1  ID presents an instruction
id_op  in  4  operation code (see Behaviour)
id_src1  in  W  register operand 1 from the register file
id_src2  in  W  operand 2 (register or immediate, already selected by ID)
id_rs1  in  REG_ADDR_WIDTH  source register index of src1
id_rs2  in  REG_ADDR_WIDTH  source register index of src2 (0 when src2 is an immediate)
id_rd  in  REG_ADDR_WIDTH  destination register
id_rd_we  in  1  destination write enable
id_instruction  in  32  raw instruction, passed through
fwd_we  in  1  MEM stage will write fwd_a
fwd_a  in  REG_ADDR_WIDTH  MEM-stage destination register
fwd_data  in  W  MEM-stage result
stall  out  1  ID must hold its outputs this cycle
ex_valid  out  1  EX/MEM buffer holds a valid instruction
ex_alu_result  out  W  result
ex_instruction  out  32  passed-through instruction
ex_rd  out  REG_ADDR_WIDTH  destination register
ex_rd_we  out  1  destination write enable

Behaviour:
- Reset (rst=0 at posedge): FSM goes to IDLE. All ex_* outputs are 0. Internal counter and operands are 0. stall is 0 while rst=0. Reset overrides everything, including reset mid-operation.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA
  - 8 SLT (signed), 9 SLTU
  - 10 MUL (low W bits of the product)
  - 11 DIVU, 12 REMU
  - 13 PASS2 (result = src2)
  - 14 and 15: result 0
- Arithmetic and width rules:
  - Wrap modulo 2^W.
  - Shift amount is src2[log2(W)-1:0].
  - SLT/SLTU produce 0 or 1, zero-extended.
- Forwarding: effective src1 = fwd_data when fwd_we && fwd_a != 0 && fwd_a == id_rs1; otherwise id_src1. Same rule for src2 with id_rs2. Evaluated combinationally in the accept cycle.
- FSM states are IDLE and BUSY.
- IDLE, single-cycle op (id_valid=1, op not 10-12):
  - stall = 0.
  - At the posedge, the EX/MEM buffer loads: ex_valid=1, result, instruction, rd, rd_we.
  - Latency is 1 cycle.
- IDLE, multi-cycle op (op 10-12), accepted in cycle T:
  - stall = 1.
  - Forwarded operands are latched and the counter is loaded with W-1.
  - At the posedge, EX/MEM loads a bubble: ex_valid=0, ex_rd_we=0, other fields 0. The FSM moves to BUSY.
- BUSY:
  - One iteration per cycle; the counter decrements.
  - stall = 1 while counter != 0.
  - In the final cycle (counter == 0), stall = 0 and the completed result is loaded into EX/MEM with ex_valid=1. The FSM returns to IDLE.
  - Timing: stall is high T..T+W-1, the result is visible from T+W+1, and ID advances at the T+W edge.
  - ID holds its outputs unchanged while stall=1. EX ignores ID inputs during BUSY (operands were latched at T).
- IDLE, id_valid=0: EX/MEM loads a bubble (all ex_* outputs 0).
- MUL: shift-add over W iterations, low W bits kept.
- DIVU/REMU: restoring division over W iterations.
  - Divide by zero gives quotient all-ones and remainder = dividend, with no exception.
- flush=1 (priority below rst, above everything else):
  - EX/MEM loads a bubble and the FSM goes to IDLE, aborting BUSY.
  - stall = 0 in the flush cycle.
- Operand x0 is never forwarded.

Test Plan:
1. ADD: id_src1=5, id_src2=7 -> next cycle ex_valid=1, ex_alu_result=12, with ex_rd/ex_rd_we/ex_instruction passed through. SUB 5-7 -> 0xFFFFFFFE.
2. Forwarding, ADD:
   - id_rs1=3, id_src1=1, id_src2=2, fwd_we=1, fwd_a=3, fwd_data=100 -> result 102.
   - Same with fwd_a=0 or fwd_we=0 -> 3.
   - id_rs2=3 matching -> src2 forwarded.
3. MUL 0xFFFFFFFF*3:
   - Result 0xFFFFFFFD.
   - stall high exactly 32 consecutive cycles.
   - ex_valid=0 during BUSY; ex_valid=1 for one cycle with the result at T+33, then the next ID instruction follows back-to-back.
4. Division:
   - DIVU 100/7 -> 14; REMU 100/7 -> 2.
   - DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
5. Shifts and compares:
   - SRA 0x80000000 by 4 -> 0xF8000000.
   - SRL same -> 0x08000000.
   - SLL 1 by 35 -> 8.
   - SLT -1,1 -> 1; SLTU -1,1 -> 0.
   - op 15 -> 0.
6. Abort mid-DIVU:
   - rst=0 at cycle T+10 -> next cycle stall=0, all ex_* 0.
   - Repeat with flush=1 -> same.
   - A following ADD 2+2 -> 4 with normal 1-cycle latency.
